// File: rtl/apb_mem_bridge.sv
// apb_mem_bridge
//   Turns each CPU data-memory strobe (mem_read/mem_write) into one APB3 master transfer.
//   The CPU is stalled until the transfer completes. The bridge returns load data and
//   keeps a sticky error flag for slave errors.
//
// Optional feature macro: APB_TIMEOUT_EN
//   Defined:   ACCESS is aborted after TIMEOUT_CYCLES cycles with PREADY low. The abort
//              sets err, returns all-ones for reads and releases stall.
//   Undefined: ACCESS waits for PREADY indefinitely. TIMEOUT_CYCLES is ignored.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   mem_read_i     CPU load request, held while stall_o=1
//   mem_write_i    CPU store request, held while stall_o=1 (wins over mem_read_i)
//   addr_i         CPU address, sampled in IDLE on request
//   wdata_i        CPU store data, sampled with addr_i
//   rdata_o        load data returned to the CPU
//   stall_o        freezes the CPU while a transfer is pending
//   err_o          sticky error flag (slave error or timeout)
//   err_clr_i      clears err_o (a simultaneous new error wins)
//   paddr_o, psel_o, penable_o, pwrite_o, pwdata_o    APB master outputs
//   prdata_i, pready_i, pslverr_i                     APB slave responses

module apb_mem_bridge #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o,
    input  logic              err_clr_i,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic req;
    logic complete;
    logic timeout;

    assign req      = mem_read_i | mem_write_i;
    assign complete = (state_q == StAccess) & pready_i;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of earlier PREADY-low ACCESS cycles, so the abort fires in the
    // cycle that brings the count to TIMEOUT_CYCLES. A ready slave in that cycle still wins.
    assign timeout = (state_q == StAccess) & ~pready_i &
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if ((state_q == StAccess) && !pready_i && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rdata_o  = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d  = StSetup;
                    paddr_d  = addr_i;
                    pwdata_d = wdata_i;
                    pwrite_d = mem_write_i;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (complete || timeout) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Read data reaches the CPU in the completion cycle, bypassing the latch.
        if (complete && !pwrite_q) begin
            rdata_d = prdata_i;
            rdata_o = prdata_i;
        end else if (timeout && !pwrite_q) begin
            rdata_d = '1;
            rdata_o = '1;
        end

        // Set is evaluated last so it beats a same-cycle clear.
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if ((complete && pslverr_i) || timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Stall is forced low during reset so a held request cannot freeze the CPU.
    assign stall_o = ~rst_i & (((state_q == StIdle) & req) | (state_q == StSetup) |
                               ((state_q == StAccess) & ~pready_i & ~timeout));

    assign psel_o    = (state_q != StIdle);
    assign penable_o = (state_q == StAccess);
    assign paddr_o   = paddr_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
module tb_apb_mem_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, err_clr;
    logic [7:0]  addr;
    logic [15:0] wdata, rdata, pwdata, prdata;
    logic        stall, err, psel, penable, pwrite, pready, pslverr;
    logic [7:0]  paddr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_mem_bridge #(
        .ADDR_W         (8),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .stall_o     (stall),
        .err_o       (err),
        .err_clr_i   (err_clr),
        .paddr_o     (paddr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    typedef struct {
        logic        wr;
        logic        both;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] prd;
        logic        serr;
        logic        clr;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One transfer with a fixed-latency slave: PREADY rises after 'waits' low ACCESS cycles.
    // Entered and left just after a rising edge; the bridge must be IDLE on entry.
    task automatic xfer(input logic wr, input logic both, input logic [7:0] a,
                        input logic [15:0] wd, input int waits, input logic [15:0] prd,
                        input logic serr, input logic clr,
                        input logic [15:0] rd_before, input logic err_before);
        int last;
        last      = 2 + waits;
        mem_write = wr;
        mem_read  = wr ? both : 1'b1;
        addr      = a;
        wdata     = wd;
        for (int k = 0; k <= last; k++) begin
            pready  = (k == last);
            prdata  = (k == last) ? prd : 16'($urandom);
            pslverr = (k == last) ? serr : 1'($urandom);
            err_clr = (k == last) ? clr : 1'b0;
            @(negedge clk);
            chk("stall", 32'(stall), 32'(k < last));
            chk("psel", 32'(psel), 32'(k >= 1));
            chk("penable", 32'(penable), 32'(k >= 2));
            if (k >= 1) begin
                chk("paddr", 32'(paddr), 32'(a));
                chk("pwrite", 32'(pwrite), 32'(wr));
                chk("pwdata", 32'(pwdata), 32'(wd));
            end
            if (k == 0 || k == last) begin
                chk("err", 32'(err), 32'(err_before));
            end
            if (k == 0) begin
                chk("rdata_idle", 32'(rdata), 32'(rd_before));
            end
            if (k == last) begin
                chk("rdata_done", 32'(rdata), 32'(wr ? rd_before : prd));
            end
            @(posedge clk);
            #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic idle(input int n, input logic [15:0] rd, input logic er);
        for (int k = 0; k < n; k++) begin
            prdata = 16'($urandom);
            @(negedge clk);
            chk("idle_psel", 32'(psel), 32'd0);
            chk("idle_penable", 32'(penable), 32'd0);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_rdata", 32'(rdata), 32'(rd));
            chk("idle_err", 32'(err), 32'(er));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] rdata_m;
        logic        err_m;
        logic        wr, both, serr, clr;
        logic [7:0]  a;
        logic [15:0] wd, prd;
        int          waits;

        //            wr  both addr   wdata     waits prd       serr clr  exp_rd    exp_err
        tbl[0] = '{1'b1, 1'b0, 8'h20, 16'hA55A, 0, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h04, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h10, 16'h7777, 0, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h11, 16'h0F0F, 0, 16'h2222, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h30, 16'h1357, 1, 16'h3333, 1'b1, 1'b0, 16'hBEEF, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h31, 16'h0000, 0, 16'h5555, 1'b0, 1'b0, 16'h5555, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h32, 16'h0000, 2, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 8'h33, 16'h2468, 0, 16'h4444, 1'b0, 1'b1, 16'h0001, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h34, 16'h0000, 1, 16'h8001, 1'b1, 1'b0, 16'h8001, 1'b1};

        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        err_clr   = 1'b0;
        addr      = 8'h00;
        wdata     = 16'h0000;
        prdata    = 16'h0000;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #2;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2, 16'h0000, 1'b0);

        // Table entries run back to back: each request appears in the IDLE cycle right
        // after the previous completion.
        for (int i = 0; i < 9; i++) begin
            xfer(tbl[i].wr, tbl[i].both, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
                 tbl[i].prd, tbl[i].serr, tbl[i].clr,
                 (i == 0) ? 16'h0000 : tbl[i-1].exp_rd,
                 (i == 0) ? 1'b0 : tbl[i-1].exp_err);
        end
        idle(2, tbl[8].exp_rd, tbl[8].exp_err);

        // Randomized transfers against a transaction-level model.
        rdata_m = tbl[8].exp_rd;
        err_m   = tbl[8].exp_err;
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom);
            both  = 1'($urandom);
            a     = 8'($urandom);
            wd    = 16'($urandom);
            waits = int'($urandom_range(0, TO - 1));
            prd   = 16'($urandom);
            serr  = ($urandom_range(0, 3) == 0);
            clr   = 1'($urandom);
            xfer(wr, both, a, wd, waits, prd, serr, clr, rdata_m, err_m);
            if (!wr) begin
                rdata_m = prd;
            end
            err_m = serr | (err_m & ~clr);
            idle(int'($urandom_range(0, 2)), rdata_m, err_m);
        end

`ifdef APB_TIMEOUT_EN
        // Unresponsive slave: abort in the TO-th ACCESS cycle.
        mem_read = 1'b1;
        addr     = 8'h40;
        pready   = 1'b0;
        for (int k = 0; k <= 1 + int'(TO); k++) begin
            @(negedge clk);
            chk("to_stall", 32'(stall), 32'(k < 1 + int'(TO)));
            chk("to_penable", 32'(penable), 32'(k >= 2));
            if (k == 1 + int'(TO)) begin
                chk("to_rdata", 32'(rdata), 32'h0000FFFF);
            end
            @(posedge clk);
            #1;
        end
        mem_read = 1'b0;
        rdata_m  = 16'hFFFF;
        err_m    = 1'b1;
        idle(2, rdata_m, err_m);
`endif

        // Make err and rdata non-zero, then reset in the middle of ACCESS.
        xfer(1'b0, 1'b0, 8'h5A, 16'h0000, 0, 16'hC0DE, 1'b1, 1'b0, rdata_m, err_m);
        mem_read = 1'b1;
        addr     = 8'h55;
        pready   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_penable", 32'(penable), 32'd1);
        chk("pre_rst_err", 32'(err), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_psel", 32'(psel), 32'd0);
        chk("midrst_penable", 32'(penable), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
